// File: rtl/conv_layer_sched.sv
// Layer controller for the 3x3 conv engine: replays the padded map once per filter pair and writes both output channels.
// Read-to-valid_in latency 1 cycle, capture-to-write 1 cycle; no backpressure, DRAIN waits on output counts.
module conv_layer_sched #(
  parameter int M  = 8,
  parameter int S  = 482,
  parameter int NF = 16,
  parameter int AW = 18,
  parameter int OW = 21,
  localparam int NP = NF / 2,
  localparam int PW = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic            clk,
  input  logic            Rst_n,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  input  logic [M-1:0]    rd_data,
  output logic [M-1:0]    din,
  output logic            valid_in,
  output logic            repeat_in,
  input  logic [2*M-1:0]  o1,
  input  logic [2*M-1:0]  o2,
  input  logic            valid_out1,
  input  logic            valid_out2,
  output logic            wr_en1,
  output logic            wr_en2,
  output logic [OW-1:0]   wr_addr1,
  output logic [OW-1:0]   wr_addr2,
  output logic [2*M-1:0]  wr_data1,
  output logic [2*M-1:0]  wr_data2,
  output logic [PW-1:0]   pass_idx
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FINISH} state_t;

  localparam int            TOT       = (S - 2) * (S - 2);
  localparam logic [AW-1:0] LAST_PIX  = AW'(S * S - 1);
  localparam logic [OW-1:0] TOT_W     = OW'(TOT);
  localparam logic [PW-1:0] LAST_PASS = PW'(NP - 1);

  state_t r_state, w_next;

  logic [AW-1:0]  r_pix;
  logic [PW-1:0]  r_pass;
  logic [OW-1:0]  r_out1, r_out2;
  logic [M-1:0]   r_din;
  logic           r_valid_in, r_repeat;
  logic           r_wr_en1, r_wr_en2;
  logic [OW-1:0]  r_wr_addr1, r_wr_addr2;
  logic [2*M-1:0] r_wr_data1, r_wr_data2;

  logic           w_rd_en, w_busy, w_done;
  logic           w_pix_last, w_full1, w_full2;
  logic           w_acc1, w_acc2, w_new_pass;
  logic [OW-1:0]  w_base;

  assign w_pix_last = (r_pix == LAST_PIX);
  assign w_full1    = (r_out1 == TOT_W);
  assign w_full2    = (r_out2 == TOT_W);
  assign w_base     = OW'(r_pass) * TOT_W;

  // Results can arrive while still streaming, so capture is open in every non-idle state.
  assign w_acc1 = valid_out1 && (r_state != IDLE) && !w_full1 && !abort;
  assign w_acc2 = valid_out2 && (r_state != IDLE) && !w_full2 && !abort;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_rd_en    = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_new_pass = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = STREAM;
      end
      STREAM: begin
        w_rd_en = 1'b1;
        w_busy  = 1'b1;
        if (w_pix_last) w_next = DRAIN;
      end
      DRAIN: begin
        w_busy = 1'b1;
        if (w_full1 && w_full2) begin
          if (r_pass == LAST_PASS) begin
            w_next = FINISH;
          end else begin
            w_next     = STREAM;
            w_new_pass = !abort;
          end
        end
      end
      FINISH: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (abort) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_pix      <= '0;
      r_pass     <= '0;
      r_out1     <= '0;
      r_out2     <= '0;
      r_din      <= '0;
      r_valid_in <= 1'b0;
      r_repeat   <= 1'b0;
      r_wr_en1   <= 1'b0;
      r_wr_en2   <= 1'b0;
      r_wr_addr1 <= '0;
      r_wr_addr2 <= '0;
      r_wr_data1 <= '0;
      r_wr_data2 <= '0;
    end else if (abort) begin
      r_pix      <= '0;
      r_pass     <= '0;
      r_out1     <= '0;
      r_out2     <= '0;
      r_din      <= '0;
      r_valid_in <= 1'b0;
      r_repeat   <= 1'b0;
      r_wr_en1   <= 1'b0;
      r_wr_en2   <= 1'b0;
      r_wr_addr1 <= '0;
      r_wr_addr2 <= '0;
      r_wr_data1 <= '0;
      r_wr_data2 <= '0;
    end else begin
      r_valid_in <= w_rd_en;
      if (w_rd_en) r_din <= rd_data;
      r_repeat <= (r_state != IDLE) && (r_pass != '0);

      if (r_state == IDLE || w_new_pass) r_pix <= '0;
      else if (r_state == STREAM && !w_pix_last) r_pix <= r_pix + AW'(1);

      if (r_state == IDLE) r_pass <= '0;
      else if (w_new_pass) r_pass <= r_pass + PW'(1);

      if (r_state == IDLE || w_new_pass) r_out1 <= '0;
      else if (w_acc1) r_out1 <= r_out1 + OW'(1);

      if (r_state == IDLE || w_new_pass) r_out2 <= '0;
      else if (w_acc2) r_out2 <= r_out2 + OW'(1);

      // Both channels share the per-pass layout; each port addresses its own filter plane.
      r_wr_en1 <= w_acc1;
      if (w_acc1) begin
        r_wr_addr1 <= w_base + r_out1;
        r_wr_data1 <= o1;
      end
      r_wr_en2 <= w_acc2;
      if (w_acc2) begin
        r_wr_addr2 <= w_base + r_out2;
        r_wr_data2 <= o2;
      end
    end
  end

  assign busy      = w_busy;
  assign done      = w_done;
  assign rd_en     = w_rd_en;
  assign rd_addr   = r_pix;
  assign din       = r_din;
  assign valid_in  = r_valid_in;
  assign repeat_in = r_repeat;
  assign wr_en1    = r_wr_en1;
  assign wr_en2    = r_wr_en2;
  assign wr_addr1  = r_wr_addr1;
  assign wr_addr2  = r_wr_addr2;
  assign wr_data1  = r_wr_data1;
  assign wr_data2  = r_wr_data2;
  assign pass_idx  = r_pass;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched at S=6, NF=4: random engine output timing against a transaction-level expectation.
module tb_conv_layer_sched;

  localparam int M    = 8;
  localparam int S    = 6;
  localparam int NF   = 4;
  localparam int AW   = 6;
  localparam int OW   = 6;
  localparam int NP   = NF / 2;
  localparam int PW   = 1;
  localparam int TOT  = (S - 2) * (S - 2);
  localparam int NPIX = S * S;

  logic           clk = 1'b0;
  logic           Rst_n = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [M-1:0]   rd_data = '0;
  logic [2*M-1:0] o1 = '0, o2 = '0;
  logic           valid_out1 = 1'b0, valid_out2 = 1'b0;
  logic           busy, done, rd_en, valid_in, repeat_in, wr_en1, wr_en2;
  logic [AW-1:0]  rd_addr;
  logic [M-1:0]   din;
  logic [OW-1:0]  wr_addr1, wr_addr2;
  logic [2*M-1:0] wr_data1, wr_data2;
  logic [PW-1:0]  pass_idx;

  conv_layer_sched #(.M(M), .S(S), .NF(NF), .AW(AW), .OW(OW)) dut (
    .clk(clk), .Rst_n(Rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .din(din), .valid_in(valid_in), .repeat_in(repeat_in),
    .o1(o1), .o2(o2), .valid_out1(valid_out1), .valid_out2(valid_out2),
    .wr_en1(wr_en1), .wr_en2(wr_en2), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
    .wr_data1(wr_data1), .wr_data2(wr_data2), .pass_idx(pass_idx)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [M-1:0] mem [NPIX];

  // Expected write for the coming cycle, derived from the pulse just driven.
  int             cnt1, cnt2, last1, last2;
  bit             exp1_vld, exp2_vld;
  logic [OW-1:0]  exp1_addr, exp2_addr;
  logic [2*M-1:0] exp1_dat, exp2_dat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({busy, done, rd_en, valid_in, repeat_in, wr_en1, wr_en2,
                            pass_idx, rd_addr, din}), 64'(0));
    chk({tag, "_dat"}, 64'({wr_addr1, wr_addr2, wr_data1, wr_data2}), 64'(0));
  endtask

  task automatic tick();
    @(negedge clk);
    chk("wr_en1", 64'(wr_en1), 64'(exp1_vld));
    if (exp1_vld) begin
      chk("wr_addr1", 64'(wr_addr1), 64'(exp1_addr));
      chk("wr_data1", 64'(wr_data1), 64'(exp1_dat));
    end
    chk("wr_en2", 64'(wr_en2), 64'(exp2_vld));
    if (exp2_vld) begin
      chk("wr_addr2", 64'(wr_addr2), 64'(exp2_addr));
      chk("wr_data2", 64'(wr_data2), 64'(exp2_dat));
    end
    exp1_vld = 1'b0; exp2_vld = 1'b0;
    valid_out1 = 1'b0; valid_out2 = 1'b0;
    start = 1'b0; abort = 1'b0;
    if (rd_en === 1'b1 && rd_addr < AW'(NPIX)) rd_data = mem[int'(rd_addr)];
    else rd_data = M'($urandom);
  endtask

  task automatic pulse1(input int p, input int c);
    valid_out1 = 1'b1;
    o1 = 16'($urandom);
    if (cnt1 < TOT) begin
      exp1_vld = 1'b1; exp1_addr = OW'(p * TOT + cnt1); exp1_dat = o1;
      cnt1++; last1 = c + 1;
    end
  endtask

  task automatic pulse2(input int p, input int c);
    valid_out2 = 1'b1;
    o2 = 16'($urandom);
    if (cnt2 < TOT) begin
      exp2_vld = 1'b1; exp2_addr = OW'(p * TOT + cnt2); exp2_dat = o2;
      cnt2++; last2 = c + 1;
    end
  endtask

  task automatic begin_layer();
    chk("idle_before_start", 64'(busy), 64'(0));
    start = 1'b1;
    tick();
  endtask

  // mode 0: independent random outputs; 1: ch2 copies ch1 five cycles late;
  // 2: ch1 back-to-back then one surplus pulse at cycle 38. Entry negedge is stream cycle 0.
  task automatic run_pass(input int p, input int mode, input int lim2, input int stop_at, input int start_at);
    int c = 0;
    int done_at, tend;
    bit [4:0] sh = '0;
    bit p1, p2;
    cnt1 = 0; cnt2 = 0; last1 = -1; last2 = -1;
    forever begin
      if (c < NPIX) begin
        chk("rd_en_stream", 64'(rd_en), 64'(1));
        chk("rd_addr", 64'(rd_addr), 64'(c));
      end
      if (c >= 1 && c <= NPIX) begin
        chk("valid_in", 64'(valid_in), 64'(1));
        chk("din", 64'(din), 64'(mem[c-1]));
        chk("repeat_in", 64'(repeat_in), 64'(p != 0));
      end else begin
        chk("valid_in_low", 64'(valid_in), 64'(0));
      end
      done_at = (cnt1 == TOT && cnt2 == TOT) ? ((last1 > last2) ? last1 : last2) : -1;
      tend = (done_at < 0) ? -1 : ((done_at + 1 > NPIX + 1) ? done_at + 1 : NPIX + 1);
      if (c == tend) begin
        if (p == NP - 1) begin
          chk("done_pulse", 64'(done), 64'(1));
          chk("busy_at_done", 64'(busy), 64'(0));
          chk("rd_en_at_done", 64'(rd_en), 64'(0));
        end
        return;
      end
      chk("busy", 64'(busy), 64'(1));
      chk("no_early_done", 64'(done), 64'(0));
      chk("pass_idx", 64'(pass_idx), 64'(p));
      if (c >= NPIX) chk("rd_en_drain", 64'(rd_en), 64'(0));
      if (c == stop_at) return;
      if (c > 400) begin
        chk("pass_end_timeout", 64'(c), 64'(tend));
        return;
      end
      if (c == start_at) start = 1'b1;
      if (mode == 2) p1 = (c < TOT) || (c == 38);
      else p1 = (cnt1 < TOT) && ($urandom_range(0, 1) == 1);
      if (mode == 1) begin
        p2 = sh[4];
        sh = {sh[3:0], p1};
      end else begin
        p2 = (cnt2 < lim2) && ($urandom_range(0, 1) == 1);
      end
      if (p1) pulse1(p, c);
      if (p2) pulse2(p, c);
      tick();
      c++;
    end
  endtask

  task automatic finish_layer();
    tick();
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("busy_after_done", 64'(busy), 64'(0));
    chk("rd_en_after_done", 64'(rd_en), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) mem[i] = M'($urandom);
    exp1_vld = 1'b0; exp2_vld = 1'b0;

    #1 Rst_n = 1'b0;
    #2 chk_all_zero("reset");
    @(negedge clk);
    Rst_n = 1'b1;
    tick();

    // Two full passes; stray start mid-stream, ch2 skewed in pass 1.
    begin_layer();
    run_pass(0, 0, TOT, -1, 10);
    run_pass(1, 1, TOT, -1, -1);
    finish_layer();

    // Abort at pixel 20, coincident with start and an engine output.
    begin_layer();
    run_pass(0, 0, TOT, 20, -1);
    abort = 1'b1; start = 1'b1;
    valid_out1 = 1'b1; o1 = 16'($urandom);
    tick();
    chk("abort_rd_en", 64'(rd_en), 64'(0));
    chk("abort_valid_in", 64'(valid_in), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_pass", 64'(pass_idx), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 64'({done, busy, rd_en}), 64'(0));
    end
    begin_layer();
    run_pass(0, 1, TOT, -1, -1);
    run_pass(1, 0, TOT, -1, -1);
    finish_layer();

    // Reset while DRAIN waits on ch2; surplus ch1 pulse must not write.
    begin_layer();
    run_pass(0, 2, 10, 40, -1);
    #2 Rst_n = 1'b0;
    valid_out1 = 1'b1; o1 = 16'($urandom);
    #1 chk_all_zero("async_reset");
    tick();
    chk("reset_busy", 64'(busy), 64'(0));
    Rst_n = 1'b1;
    tick();
    begin_layer();
    run_pass(0, 0, TOT, -1, -1);
    run_pass(1, 0, TOT, -1, -1);
    finish_layer();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
